// File: rtl/enc_pkg.sv
// Shared encoder definitions: default geometry, segment-walk FSM states, dim word type.
package enc_pkg;

  localparam int FEATURE_COUNT = 617;
  localparam int HV_DIM        = 4096;
  localparam int DIMS_PER_CC   = 1024;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } seg_state_t;

  typedef logic [FEATURE_COUNT-1:0] dim_word_t;

endpackage

// File: rtl/enc_seg_next.sv
// Next-segment finder for the segment walk. With ENC_SEG_PRUNE_EN it returns the lowest set
// mask bit above cur (or at/after 0 when from_start); otherwise it is a plain +1 with last detect.
module enc_seg_next
  import enc_pkg::*;
#(
  parameter int NUM_SEG = 4,
  parameter int SEG_W   = 2
) (
`ifdef ENC_SEG_PRUNE_EN
  input  logic [NUM_SEG-1:0] mask,
`endif
  input  logic               from_start,
  input  logic [SEG_W-1:0]   cur,
  output logic [SEG_W-1:0]   next_idx,
  output logic               none_left
);

`ifdef ENC_SEG_PRUNE_EN
  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    next_idx  = '0;
    none_left = 1'b1;
    for (int i = NUM_SEG - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur)))) begin
        next_idx  = SEG_W'(i);
        none_left = 1'b0;
      end
    end
  end
`else
  always_comb begin
    if (from_start) begin
      next_idx  = '0;
      none_left = 1'b0;
    end else begin
      next_idx  = cur + 1'b1;
      none_left = (cur == SEG_W'(NUM_SEG - 1));
    end
  end
`endif

endmodule

// File: rtl/enc_seg_sequencer.sv
// Walks the bits-to-bundle array one DIMS_PER_CC-wide segment per beat over valid/ready.
// Optional feature macro: ENC_SEG_PRUNE_EN (seg_mask input, captured at start, skips segments).
module enc_seg_sequencer
  import enc_pkg::*;
#(
  parameter int FEATURE_COUNT = enc_pkg::FEATURE_COUNT,
  parameter int HV_DIM        = enc_pkg::HV_DIM,
  parameter int DIMS_PER_CC   = enc_pkg::DIMS_PER_CC,
  localparam int NUM_SEG      = HV_DIM / DIMS_PER_CC,
  localparam int SEG_W        = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
`ifdef ENC_SEG_PRUNE_EN
  input  logic [NUM_SEG-1:0]       seg_mask,
`endif
  input  logic [FEATURE_COUNT-1:0] bits_to_bundle_arr [HV_DIM],
  output logic [FEATURE_COUNT-1:0] out_data [DIMS_PER_CC],
  output logic [SEG_W-1:0]         out_seg_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;

  seg_state_t               state_q, state_d;
  logic [SEG_W-1:0]         cur_seg_q, cur_seg_d;
  logic [FEATURE_COUNT-1:0] out_data_q [DIMS_PER_CC];
  logic [FEATURE_COUNT-1:0] out_data_d [DIMS_PER_CC];
  logic [SEG_W-1:0]         out_seg_idx_q, out_seg_idx_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [SEG_W-1:0]         nxt_idx;
  logic                     nxt_none;

`ifdef ENC_SEG_PRUNE_EN
  logic [NUM_SEG-1:0] mask_q, mask_d;
  logic [NUM_SEG-1:0] finder_mask;

  // In IDLE the mask register is not yet loaded, so the first lookup uses the live input.
  assign finder_mask = (state_q == IDLE) ? seg_mask : mask_q;
`endif

  enc_seg_next #(
    .NUM_SEG (NUM_SEG),
    .SEG_W   (SEG_W)
  ) u_next (
`ifdef ENC_SEG_PRUNE_EN
    .mask       (finder_mask),
`endif
    .from_start (state_q == IDLE),
    .cur        (cur_seg_q),
    .next_idx   (nxt_idx),
    .none_left  (nxt_none)
  );

  always_comb begin
    state_d       = state_q;
    cur_seg_d     = cur_seg_q;
    out_data_d    = out_data_q;
    out_seg_idx_d = out_seg_idx_q;
    out_valid_d   = out_valid_q;
`ifdef ENC_SEG_PRUNE_EN
    mask_d        = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef ENC_SEG_PRUNE_EN
          mask_d = seg_mask;
`endif
          if (nxt_none) begin
            state_d = DONE;
          end else begin
            cur_seg_d = nxt_idx;
            state_d   = LOAD;
          end
        end
      end
      LOAD: begin
        for (int i = 0; i < DIMS_PER_CC; i++) begin
          out_data_d[i] = bits_to_bundle_arr[AW'(int'(cur_seg_q) * DIMS_PER_CC + i)];
        end
        out_seg_idx_d = cur_seg_q;
        out_valid_d   = 1'b1;
        state_d       = SEND;
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (nxt_none) begin
            state_d = DONE;
          end else begin
            cur_seg_d = nxt_idx;
            state_d   = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Status flags are registered from the next state so they line up with the FSM.
    busy_d = (state_d == LOAD) || (state_d == SEND);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_seg_q     <= '0;
      out_seg_idx_q <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      for (int i = 0; i < DIMS_PER_CC; i++) begin
        out_data_q[i] <= '0;
      end
`ifdef ENC_SEG_PRUNE_EN
      mask_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cur_seg_q     <= cur_seg_d;
      out_seg_idx_q <= out_seg_idx_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      out_data_q    <= out_data_d;
`ifdef ENC_SEG_PRUNE_EN
      mask_q        <= mask_d;
`endif
    end
  end

  assign out_data    = out_data_q;
  assign out_seg_idx = out_seg_idx_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_enc_seg_sequencer.sv
// Directed bench for enc_seg_sequencer; pruning cases run only when ENC_SEG_PRUNE_EN is defined.
module tb_enc_seg_sequencer;
  import enc_pkg::*;

  localparam int FC  = 617;
  localparam int HV  = 4096;
  localparam int DPC = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       out_ready;
`ifdef ENC_SEG_PRUNE_EN
  logic [3:0] seg_mask;
`endif
  dim_word_t  arr      [HV];
  dim_word_t  out_data [DPC];
  logic [1:0] out_seg_idx;
  logic       out_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  enc_seg_sequencer #(
    .FEATURE_COUNT (FC),
    .HV_DIM        (HV),
    .DIMS_PER_CC   (DPC)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
`ifdef ENC_SEG_PRUNE_EN
    .seg_mask           (seg_mask),
`endif
    .bits_to_bundle_arr (arr),
    .out_data           (out_data),
    .out_seg_idx        (out_seg_idx),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .busy               (busy),
    .done               (done)
  );

  function automatic dim_word_t pat(input int d);
    dim_word_t w;
    w            = '0;
    w[31:0]      = 32'(d * 3 + 1);
    w[FC-1 -: 16] = 16'(d);
    return w;
  endfunction

  task automatic chk(input string tag, input dim_word_t got, input dim_word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one pass from a start pulse (or held start) and checks every beat against exp_q.
  task automatic run_pass(input string name, input bit keep_start, input int stall_seg,
                          input bit chg_mask, input logic [3:0] new_mask);
    int        k         = 0;
    int        last_acc  = -10;
    int        first_val = -1;
    int        stalled   = 0;
    bit        got_done  = 1'b0;
    dim_word_t hold0;
    logic [1:0] hold_idx;
    hold0    = '0;
    hold_idx = '0;
    start     = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 80 && !got_done; cyc++) begin
      step();
      if (!keep_start) start = 1'b0;
`ifdef ENC_SEG_PRUNE_EN
      if (chg_mask && cyc == 1) seg_mask = new_mask;
`else
      if (chg_mask && cyc == 1) hold_idx = new_mask[1:0];
`endif
      if (cyc == 1)
        chk({name, " busy@t+1"}, dim_word_t'(busy), dim_word_t'(exp_q.size() != 0));
      if (out_valid && first_val < 0) begin
        first_val = cyc;
        chk({name, " first_valid_latency"}, dim_word_t'(cyc), dim_word_t'(2));
      end
      if (done) begin
        got_done = 1'b1;
        start    = 1'b0;
        chk({name, " beats"}, dim_word_t'(k), dim_word_t'(exp_q.size()));
        if (exp_q.size() == 0)
          chk({name, " done@t+1"}, dim_word_t'(cyc), dim_word_t'(1));
        else
          chk({name, " done_after_last"}, dim_word_t'(cyc), dim_word_t'(last_acc + 1));
      end else if (out_valid) begin
        if (stall_seg >= 0 && int'(out_seg_idx) == stall_seg && stalled == 0) begin
          out_ready = 1'b0;
          hold0     = out_data[0];
          hold_idx  = out_seg_idx;
          stalled   = 1;
        end else if (stalled >= 1 && stalled <= 5) begin
          chk({name, " stall_idx"}, dim_word_t'(out_seg_idx), dim_word_t'(hold_idx));
          chk({name, " stall_data"}, out_data[0], hold0);
          chk({name, " stall_valid"}, dim_word_t'(out_valid), dim_word_t'(1));
          if (stalled == 5) out_ready = 1'b1;
          stalled++;
        end
        if (out_ready) begin
          if (k < exp_q.size()) begin
            chk({name, " seg_idx"}, dim_word_t'(out_seg_idx), dim_word_t'(exp_q[k]));
            chk({name, " data_lo"}, out_data[0], pat(exp_q[k] * DPC));
            chk({name, " data_hi"}, out_data[DPC-1], pat(exp_q[k] * DPC + DPC - 1));
          end else begin
            chk({name, " extra_beat"}, dim_word_t'(k), dim_word_t'(exp_q.size()));
          end
          k++;
          last_acc = cyc;
        end
      end
    end
    if (!got_done) chk({name, " done_timeout"}, dim_word_t'(0), dim_word_t'(1));
    out_ready = 1'b1;
    step();
    chk({name, " done_one_cycle"}, dim_word_t'(done), dim_word_t'(0));
    chk({name, " idle_busy"}, dim_word_t'(busy), dim_word_t'(0));
    chk({name, " idle_valid"}, dim_word_t'(out_valid), dim_word_t'(0));
    step();
    chk({name, " no_second_pass"}, dim_word_t'(busy), dim_word_t'(0));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
`ifdef ENC_SEG_PRUNE_EN
    seg_mask  = 4'b1111;
`endif
    for (int d = 0; d < HV; d++) arr[d] = pat(d);
    step();
    step();
    chk("reset_valid", dim_word_t'(out_valid), dim_word_t'(0));
    chk("reset_busy", dim_word_t'(busy), dim_word_t'(0));
    chk("reset_done", dim_word_t'(done), dim_word_t'(0));
    chk("reset_idx", dim_word_t'(out_seg_idx), dim_word_t'(0));
    chk("reset_data", out_data[0], dim_word_t'(0));
    rst = 1'b0;
    step();

    exp_q = '{0, 1, 2, 3};
    run_pass("full_pass", 1'b0, -1, 1'b0, 4'b0000);
    run_pass("backpressure", 1'b0, 2, 1'b0, 4'b0000);
    run_pass("start_held", 1'b1, -1, 1'b0, 4'b0000);

    // Reset in the middle of a pass, while segment 1 is presented.
    start     = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_seg_idx == 2'd1) break;
      step();
    end
    chk("midrst_reached_seg1", dim_word_t'(out_seg_idx), dim_word_t'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", dim_word_t'(out_valid), dim_word_t'(0));
    chk("midrst_busy", dim_word_t'(busy), dim_word_t'(0));
    chk("midrst_data", out_data[0], dim_word_t'(0));
    chk("midrst_idx", dim_word_t'(out_seg_idx), dim_word_t'(0));
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_done", dim_word_t'(done), dim_word_t'(0));
      step();
    end
    run_pass("after_rst", 1'b0, -1, 1'b0, 4'b0000);

`ifdef ENC_SEG_PRUNE_EN
    seg_mask = 4'b1010;
    exp_q    = '{1, 3};
    run_pass("mask_1010", 1'b0, -1, 1'b0, 4'b0000);
    seg_mask = 4'b0000;
    exp_q    = {};
    run_pass("mask_0000", 1'b0, -1, 1'b0, 4'b0000);
    seg_mask = 4'b1010;
    exp_q    = '{1, 3};
    run_pass("mask_change", 1'b0, -1, 1'b1, 4'b0101);
    seg_mask = 4'b1111;
    exp_q    = '{0, 1, 2, 3};
    run_pass("mask_all", 1'b0, -1, 1'b0, 4'b0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
